// File: rtl/phase_seq_ctrl.sv
// One-hot phase sequencer: steps an MSB-first one-hot pulse across N_PH outputs,
// holding each phase for a latched dwell, in single-pass or continuous mode.
module phase_seq_ctrl #(
    parameter int N_PH  = 4,
    parameter int CNT_W = 8,
    parameter int PH_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] dwell,
    input  logic [PH_W-1:0]  nph,
    output logic [N_PH-1:0]  q,
    output logic [PH_W-1:0]  phase_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N_PH-1:0]  MSB_OH  = {1'b1, {(N_PH-1){1'b0}}};
    localparam logic [PH_W-1:0]  NPH_MAX = PH_W'(N_PH);
    localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic             mode_q;
    logic             stop_pend_q;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PH_W-1:0]  nph_q;

    logic [CNT_W-1:0] dwell_d;
    logic [PH_W-1:0]  nph_d;
    logic             last_ph;

    // Clamp the configuration as it is latched so the run logic never sees 0 or >N_PH.
    always_comb begin
        dwell_d = (dwell == '0) ? CNT_ONE : dwell;
        nph_d   = ((nph == '0) || (nph > NPH_MAX)) ? NPH_MAX : nph;
        last_ph = (phase_idx == (nph_q - PH_ONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            q           <= '0;
            phase_idx   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            mode_q      <= 1'b0;
            dwell_q     <= CNT_ONE;
            nph_q       <= NPH_MAX;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q     <= RUN;
                        mode_q      <= mode;
                        dwell_q     <= dwell_d;
                        nph_q       <= nph_d;
                        stop_pend_q <= stop;
                        q           <= MSB_OH;
                        phase_idx   <= '0;
                        busy        <= 1'b1;
                        cnt_q       <= dwell_d - CNT_ONE;
                    end
                end
                RUN: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (!last_ph) begin
                        q         <= q >> 1;
                        phase_idx <= phase_idx + PH_ONE;
                        cnt_q     <= dwell_q - CNT_ONE;
                    end else if (mode_q && !stop_pend_q) begin
                        q         <= MSB_OH;
                        phase_idx <= '0;
                        cnt_q     <= dwell_q - CNT_ONE;
                    end else begin
                        state_q   <= DONE;
                        q         <= '0;
                        phase_idx <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    done        <= 1'b0;
                    stop_pend_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    q       <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
